wavetable_mc: RTL

Multi-channel, time-multiplexed wavetable synthesiser for expansion-audio mappers, generalising the single-voice FDS-style wavetable path. Up to 8 channels share one wave RAM; each channel has its own phase accumulator, wave base/length and volume envelope. Channels are serviced round-robin on CPU-cycle ticks, and their products are summed into one mixed output that feeds the mapper audio mixer.

---
 rtl/wavetable_mc.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/wavetable_mc.sv
// wavetable_mc: time-multiplexed multi-channel wavetable synthesiser.
// Up to 8 voices share one wave RAM. One voice is serviced per tick in
// round-robin order, and the per-voice products are summed into one frame mix.
//   clk, reset   : system clock, synchronous active-high reset
//   tick         : one-clk strobe per CPU cycle (>= 3 clk apart)
//   wr/addr/wdata: register write port, sampled only on tick
//   rdata        : combinational register / wave RAM read data
//   audio_out    : mixed unsigned output, updated once per frame
module wavetable_mc #(
  parameter int CHANNELS = 4,
  parameter int RAM_AW   = 7,
  parameter int SAMPLE_W = 6,
  parameter int FREQ_W   = 12,
  parameter int OUT_W    = 12 + $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             wr,
  input  logic [7:0]       addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic [OUT_W-1:0] audio_out
);
  localparam int PTR_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RAM_D  = 1 << RAM_AW;
  localparam int PROD_W = SAMPLE_W + 6;
  localparam int MIX_W  = PROD_W + PTR_W + 1;

  // per-channel state
  logic [23:0]       acc_q    [CHANNELS], acc_d    [CHANNELS];
  logic [FREQ_W-1:0] freq_q   [CHANNELS], freq_d   [CHANNELS];
  logic              halt_q   [CHANNELS], halt_d   [CHANNELS];
  logic [6:0]        base_q   [CHANNELS], base_d   [CHANNELS];
  logic [1:0]        len_q    [CHANNELS], len_d    [CHANNELS];
  logic              direct_q [CHANNELS], direct_d [CHANNELS];
  logic              dir_q    [CHANNELS], dir_d    [CHANNELS];
  logic [5:0]        speed_q  [CHANNELS], speed_d  [CHANNELS];
  logic [5:0]        gain_q   [CHANNELS], gain_d   [CHANNELS];
  logic [5:0]        envc_q   [CHANNELS], envc_d   [CHANNELS];

  // globals
  logic             wave_wren_q, wave_wren_d;
  logic [1:0]       master_q, master_d;
  logic [7:0]       env_prescale_q, env_prescale_d;
  logic [10:0]      pre_cnt_q, pre_cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [SAMPLE_W-1:0] wave_ram [RAM_D];

  // pipeline
  logic                s0_vld_q, s0_vld_d, s0_last_q, s0_last_d;
  logic [5:0]          s0_vol_q, s0_vol_d;
  logic [SAMPLE_W-1:0] ram_rd_q, ram_rd_d;
  logic                s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic [5:0]          s1_vol_q, s1_vol_d;
  logic [SAMPLE_W-1:0] s1_sample_q, s1_sample_d;
  logic                s2_last_q, s2_last_d;
  logic [MIX_W-1:0]    mix_q, mix_d;
  logic [OUT_W-1:0]    audio_q, audio_d;

  // decode / service
  logic wr_en, ch_space, ram_space, ram_we, env_match, env_clk, hit;
  logic [23:0]         svc_acc;
  logic [FREQ_W-1:0]   svc_freq;
  logic                svc_halt;
  logic [6:0]          svc_base, svc_idx;
  logic [1:0]          svc_len;
  logic [5:0]          svc_gain, svc_vol;
  logic [7:0]          svc_sum;
  logic [RAM_AW-1:0]   svc_addr;
  logic [PROD_W-1:0]   prod;

  always_comb begin
    wr_en     = tick & wr;
    ch_space  = (addr[7:6] == 2'b00) && (int'(addr[5:3]) < CHANNELS);
    ram_space = addr[7] && (int'(addr[6:0]) < RAM_D);
    ram_we    = wr_en && ram_space && wave_wren_q;

    svc_acc  = '0;
    svc_freq = '0;
    svc_halt = 1'b1;
    svc_base = '0;
    svc_len  = '0;
    svc_gain = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (ptr_q == PTR_W'(c)) begin
        svc_acc  = acc_q[c];
        svc_freq = freq_q[c];
        svc_halt = halt_q[c];
        svc_base = base_q[c];
        svc_len  = len_q[c];
        svc_gain = gain_q[c];
      end
    end
    svc_idx  = svc_acc[23:17] >> (2'd3 - svc_len);
    svc_sum  = {1'b0, svc_base} + {1'b0, svc_idx};
    svc_addr = svc_sum[RAM_AW-1:0];
    // a halted voice still flows through the pipeline so the frame-end marker survives
    svc_vol  = svc_halt ? 6'd0 : ((svc_gain > 6'd32) ? 6'd32 : svc_gain);

    env_match = (pre_cnt_q == {env_prescale_q, 3'b111});
    env_clk   = tick && (env_prescale_q != 8'd0) && env_match;
    pre_cnt_d = pre_cnt_q;
    if (tick && (env_prescale_q != 8'd0)) pre_cnt_d = env_match ? 11'd0 : pre_cnt_q + 11'd1;
    if (wr_en && (addr == 8'h41)) pre_cnt_d = '0;

    wave_wren_d    = wave_wren_q;
    master_d       = master_q;
    env_prescale_d = env_prescale_q;
    if (wr_en && (addr == 8'h40)) begin
      wave_wren_d = wdata[7];
      master_d    = wdata[1:0];
    end
    if (wr_en && (addr == 8'h41)) env_prescale_d = wdata;

    ptr_d = ptr_q;
    if (tick) ptr_d = (ptr_q == PTR_W'(CHANNELS - 1)) ? '0 : ptr_q + PTR_W'(1);

    acc_d = acc_q;  freq_d = freq_q;   halt_d = halt_q;  base_d  = base_q;
    len_d = len_q;  direct_d = direct_q; dir_d = dir_q;  speed_d = speed_q;
    gain_d = gain_q; envc_d = envc_q;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (tick && (ptr_q == PTR_W'(c)) && !halt_q[c]) acc_d[c] = acc_q[c] + 24'(freq_q[c]);
      if (env_clk && !direct_q[c]) begin
        if (envc_q[c] == speed_q[c]) begin
          envc_d[c] = '0;
          if (dir_q[c]) gain_d[c] = (gain_q[c] >= 6'd32) ? 6'd32 : gain_q[c] + 6'd1;
          else          gain_d[c] = (gain_q[c] == 6'd0) ? 6'd0 : gain_q[c] - 6'd1;
        end else begin
          envc_d[c] = envc_q[c] + 6'd1;
        end
      end
      // register writes are applied last so they override service and envelope updates
      hit = wr_en && ch_space && (addr[5:3] == 3'(c));
      if (hit) begin
        case (addr[2:0])
          3'd0: freq_d[c][7:0] = wdata;
          3'd1: begin
            halt_d[c] = wdata[7];
            freq_d[c][FREQ_W-1:8] = wdata[FREQ_W-9:0];
            if (wdata[7]) acc_d[c] = '0;
          end
          3'd2: base_d[c] = wdata[6:0];
          3'd3: len_d[c]  = wdata[1:0];
          3'd4: begin
            direct_d[c] = wdata[7];
            dir_d[c]    = wdata[6];
            speed_d[c]  = wdata[5:0];
            envc_d[c]   = '0;
            if (wdata[7]) gain_d[c] = wdata[5:0];
          end
          default: ;
        endcase
      end
    end

    s0_vld_d    = tick;
    s0_last_d   = tick && (ptr_q == PTR_W'(CHANNELS - 1));
    s0_vol_d    = tick ? svc_vol : s0_vol_q;
    // read registered on the tick edge, so a same-tick RAM write is not visible
    ram_rd_d    = tick ? wave_ram[svc_addr] : ram_rd_q;
    s1_vld_d    = s0_vld_q;
    s1_last_d   = s0_last_q;
    s1_vol_d    = s0_vol_q;
    s1_sample_d = ram_rd_q;
    prod        = PROD_W'(s1_sample_q) * PROD_W'(s1_vol_q);
    s2_last_d   = s1_vld_q && s1_last_q;
    mix_d       = (s2_last_q ? '0 : mix_q) + (s1_vld_q ? MIX_W'(prod) : '0);
    audio_d     = s2_last_q ? OUT_W'(mix_q >> master_q) : audio_q;
  end

  always_comb begin
    rdata = '0;
    if (addr[7]) begin
      if (ram_space) rdata = 8'(wave_ram[addr[RAM_AW-1:0]]);
    end else if (addr == 8'h40) begin
      rdata = {wave_wren_q, 5'b0, master_q};
    end else if (addr == 8'h41) begin
      rdata = env_prescale_q;
    end else if (ch_space) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (addr[5:3] == 3'(c)) begin
          case (addr[2:0])
            3'd0:    rdata = freq_q[c][7:0];
            3'd1:    rdata = {halt_q[c], 7'(freq_q[c][FREQ_W-1:8])};
            3'd2:    rdata = {1'b0, base_q[c]};
            3'd3:    rdata = {6'b0, len_q[c]};
            3'd4:    rdata = {direct_q[c], dir_q[c], speed_q[c]};
            3'd5:    rdata = {2'b00, gain_q[c]};
            default: rdata = '0;
          endcase
        end
      end
    end
  end

  assign audio_out = audio_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= '0;  freq_q[c] <= '0;  halt_q[c] <= 1'b1;  base_q[c] <= '0;
        len_q[c] <= '0;  direct_q[c] <= 1'b0; dir_q[c] <= 1'b0; speed_q[c] <= '0;
        gain_q[c] <= '0; envc_q[c] <= '0;
      end
      wave_wren_q    <= 1'b0;
      master_q       <= '0;
      env_prescale_q <= 8'hE8;
      pre_cnt_q      <= '0;
      ptr_q          <= '0;
      s0_vld_q       <= 1'b0;
      s0_last_q      <= 1'b0;
      s1_vld_q       <= 1'b0;
      s1_last_q      <= 1'b0;
      s2_last_q      <= 1'b0;
      mix_q          <= '0;
      audio_q        <= '0;
    end else begin
      acc_q <= acc_d;  freq_q <= freq_d;  halt_q <= halt_d;  base_q <= base_d;
      len_q <= len_d;  direct_q <= direct_d; dir_q <= dir_d; speed_q <= speed_d;
      gain_q <= gain_d; envc_q <= envc_d;
      wave_wren_q    <= wave_wren_d;
      master_q       <= master_d;
      env_prescale_q <= env_prescale_d;
      pre_cnt_q      <= pre_cnt_d;
      ptr_q          <= ptr_d;
      s0_vld_q       <= s0_vld_d;
      s0_last_q      <= s0_last_d;
      s1_vld_q       <= s1_vld_d;
      s1_last_q      <= s1_last_d;
      s2_last_q      <= s2_last_d;
      mix_q          <= mix_d;
      audio_q        <= audio_d;
    end
  end

  // data path and wave RAM: qualified by the valid flags, so no reset needed
  always_ff @(posedge clk) begin
    s0_vol_q    <= s0_vol_d;
    ram_rd_q    <= ram_rd_d;
    s1_vol_q    <= s1_vol_d;
    s1_sample_q <= s1_sample_d;
    if (ram_we) wave_ram[addr[RAM_AW-1:0]] <= wdata[SAMPLE_W-1:0];
  end
endmodule
